data_path: RTL and testbench



---
 rtl/data_path_pkg.sv | 29 ++
 rtl/data_path_reg_file.sv | 40 ++++
 rtl/data_path.sv | 111 +++++++++++
 tb/tb_data_path.sv | 288 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/data_path_pkg.sv
// Shared encodings for the single-cycle RV32I datapath.
// ALU operation codes, immediate format codes and write-back source codes used by
// data_path and its control unit.
package data_path_pkg;

    typedef enum logic [2:0] {
        ALU_ADD = 3'b000,
        ALU_SUB = 3'b001,
        ALU_AND = 3'b010,
        ALU_OR  = 3'b011,
        ALU_XOR = 3'b100,
        ALU_SLT = 3'b101
    } aluOp_e;

    typedef enum logic [1:0] {
        IMM_I = 2'b00,
        IMM_S = 2'b01,
        IMM_B = 2'b10,
        IMM_J = 2'b11
    } immSrc_e;

    typedef enum logic [1:0] {
        RES_ALU = 2'b00,
        RES_MEM = 2'b01,
        RES_PC4 = 2'b10,
        RES_IMM = 2'b11
    } resSrc_e;

endpackage

// File: rtl/data_path_reg_file.sv
// 32x32 register file: two combinational read ports, one synchronous write port.
// x0 reads as zero and ignores writes. Synchronous active-high reset loads x1..x31
// with 1 when DATAPATH_REG_PRESET_EN is defined, otherwise clears them.
// Ports: clk, rst, we (write enable), ra1/ra2 (read addresses), wa/wd (write
// address/data), rd1/rd2 (read data).
module data_path_reg_file (
    input  logic        clk,
    input  logic        rst,
    input  logic        we,
    input  logic [4:0]  ra1,
    input  logic [4:0]  ra2,
    input  logic [4:0]  wa,
    input  logic [31:0] wd,
    output logic [31:0] rd1,
    output logic [31:0] rd2
);

`ifdef DATAPATH_REG_PRESET_EN
    localparam logic [31:0] RegResetVal = 32'd1;
`else
    localparam logic [31:0] RegResetVal = 32'd0;
`endif

    // x0 has no storage.
    logic [31:0] regs [1:31];

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 1; i < 32; i++) begin
                regs[i] <= RegResetVal;
            end
        end else if (we && (wa != 5'd0)) begin
            regs[wa] <= wd;
        end
    end

    assign rd1 = (ra1 == 5'd0) ? 32'd0 : regs[ra1];
    assign rd2 = (ra2 == 5'd0) ? 32'd0 : regs[ra2];

endmodule

// File: rtl/data_path.sv
// Single-cycle RV32I datapath: PC, register file, immediate extender, ALU and
// write-back multiplexer. Control comes from an external control unit; instruction
// and data memories are external.
// Inputs: clk, rst (sync, active-high), branch, jump, readData, resultSrc, inmSrc,
//   instr, regWrite, aluSrc, aluControl.
// Outputs: aluRes (also data address), zero, op, f3, f7 (decode fields for control),
//   writeData (store data), pc (16-bit current PC).
// Build option: DATAPATH_REG_PRESET_EN presets x1..x31 to 1 on reset.
module data_path
    import data_path_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        branch,
    input  logic        jump,
    input  logic [31:0] readData,
    input  logic [1:0]  resultSrc,
    input  logic [1:0]  inmSrc,
    input  logic [31:0] instr,
    input  logic        regWrite,
    input  logic        aluSrc,
    input  logic [2:0]  aluControl,
    output logic [31:0] aluRes,
    output logic        zero,
    output logic [6:0]  op,
    output logic [2:0]  f3,
    output logic        f7,
    output logic [31:0] writeData,
    output logic [15:0] pc
);

    logic [31:0] srcA;
    logic [31:0] srcB;
    logic [31:0] immExt;
    logic [31:0] result;
    logic [15:0] pcQ;
    logic [15:0] pcD;
    logic [15:0] pcPlus4;
    logic [15:0] pcTarget;

    assign op = instr[6:0];
    assign f3 = instr[14:12];
    assign f7 = instr[30];

    data_path_reg_file regFile (
        .clk (clk),
        .rst (rst),
        .we  (regWrite),
        .ra1 (instr[19:15]),
        .ra2 (instr[24:20]),
        .wa  (instr[11:7]),
        .wd  (result),
        .rd1 (srcA),
        .rd2 (writeData)
    );

    always_comb begin
        immExt = 32'd0;
        unique case (inmSrc)
            IMM_I:   immExt = {{20{instr[31]}}, instr[31:20]};
            IMM_S:   immExt = {{20{instr[31]}}, instr[31:25], instr[11:7]};
            IMM_B:   immExt = {{20{instr[31]}}, instr[7], instr[30:25], instr[11:8], 1'b0};
            IMM_J:   immExt = {{12{instr[31]}}, instr[19:12], instr[20], instr[30:21], 1'b0};
            default: immExt = 32'd0;
        endcase
    end

    assign srcB = aluSrc ? immExt : writeData;

    always_comb begin
        aluRes = 32'd0;
        case (aluControl)
            ALU_ADD: aluRes = srcA + srcB;
            ALU_SUB: aluRes = srcA - srcB;
            ALU_AND: aluRes = srcA & srcB;
            ALU_OR:  aluRes = srcA | srcB;
            ALU_XOR: aluRes = srcA ^ srcB;
            ALU_SLT: aluRes = {31'd0, $signed(srcA) < $signed(srcB)};
            default: aluRes = 32'd0;
        endcase
    end

    assign zero = (aluRes == 32'd0);

    assign pcPlus4  = pcQ + 16'd4;
    assign pcTarget = pcQ + immExt[15:0];

    always_comb begin
        result = aluRes;
        unique case (resultSrc)
            RES_ALU: result = aluRes;
            RES_MEM: result = readData;
            RES_PC4: result = {16'd0, pcPlus4};
            RES_IMM: result = immExt;
            default: result = aluRes;
        endcase
    end

    assign pcD = (jump || (branch && zero)) ? pcTarget : pcPlus4;

    always_ff @(posedge clk) begin
        if (rst) begin
            pcQ <= 16'd0;
        end else begin
            pcQ <= pcD;
        end
    end

    assign pc = pcQ;

endmodule

// File: tb/tb_data_path.sv
// Randomized + directed scoreboard bench for data_path. The stimulus process
// computes expected outputs from a behavioural model and queues them; a monitor
// pops and compares on each falling edge.
module tb_data_path;

    logic        clk = 1'b0;
    logic        rst;
    logic        branch;
    logic        jump;
    logic [31:0] readData;
    logic [1:0]  resultSrc;
    logic [1:0]  inmSrc;
    logic [31:0] instr;
    logic        regWrite;
    logic        aluSrc;
    logic [2:0]  aluControl;
    logic [31:0] aluRes;
    logic        zero;
    logic [6:0]  op;
    logic [2:0]  f3;
    logic        f7;
    logic [31:0] writeData;
    logic [15:0] pc;

    data_path dut (
        .clk        (clk),
        .rst        (rst),
        .branch     (branch),
        .jump       (jump),
        .readData   (readData),
        .resultSrc  (resultSrc),
        .inmSrc     (inmSrc),
        .instr      (instr),
        .regWrite   (regWrite),
        .aluSrc     (aluSrc),
        .aluControl (aluControl),
        .aluRes     (aluRes),
        .zero       (zero),
        .op         (op),
        .f3         (f3),
        .f7         (f7),
        .writeData  (writeData),
        .pc         (pc)
    );

    always #5 clk = ~clk;

`ifdef DATAPATH_REG_PRESET_EN
    localparam logic [31:0] ResetVal = 32'd1;
`else
    localparam logic [31:0] ResetVal = 32'd0;
`endif

    typedef struct {
        logic [31:0] aluRes;
        logic        zero;
        logic [31:0] writeData;
        logic [15:0] pc;
        logic [6:0]  op;
        logic [2:0]  f3;
        logic        f7;
    } exp_t;

    exp_t expQ[$];
    int total = 0;
    int bad = 0;

    // Reference state: architectural registers and PC.
    logic [31:0] mRegs [32];
    logic [15:0] mPc;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, req, $time);
        end
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            if (expQ.size() > 0) begin
                e = expQ.pop_front();
                chk("pc", {16'd0, pc}, {16'd0, e.pc});
                chk("aluRes", aluRes, e.aluRes);
                chk("zero", {31'd0, zero}, {31'd0, e.zero});
                chk("writeData", writeData, e.writeData);
                chk("op", {25'd0, op}, {25'd0, e.op});
                chk("f3", {29'd0, f3}, {29'd0, e.f3});
                chk("f7", {31'd0, f7}, {31'd0, e.f7});
            end
        end
    end

    function automatic logic [31:0] immOf(input logic [31:0] ins, input logic [1:0] sel);
        logic signed [31:0] v;
        case (sel)
            2'd0: v = $signed(ins) >>> 20;
            2'd1: v = (($signed(ins) >>> 25) * 32) + int'(ins[11:7]);
            2'd2: v = (($signed(ins) >>> 31) * 4096) + int'(ins[7]) * 2048
                      + int'(ins[30:25]) * 32 + int'(ins[11:8]) * 2;
            default: v = (($signed(ins) >>> 31) * 1048576) + int'(ins[19:12]) * 4096
                      + int'(ins[20]) * 2048 + int'(ins[30:21]) * 2;
        endcase
        return v;
    endfunction

    function automatic logic [31:0] aluOf(input logic [31:0] a, input logic [31:0] b,
                                          input logic [2:0] ctl);
        case (ctl)
            3'd0: return a + b;
            3'd1: return a - b;
            3'd2: return a & b;
            3'd3: return a | b;
            3'd4: return a ^ b;
            3'd5: return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            default: return 32'd0;
        endcase
    endfunction

    task automatic setc(input logic br, input logic jp, input logic [1:0] rs,
                        input logic [1:0] is, input logic rw, input logic as,
                        input logic [2:0] ac, input logic [31:0] ins, input logic [31:0] rdat);
        branch = br; jump = jp; resultSrc = rs; inmSrc = is; regWrite = rw;
        aluSrc = as; aluControl = ac; instr = ins; readData = rdat;
    endtask

    // One cycle: predict outputs for current inputs, let the edge happen, advance model.
    task automatic step(input bit doCheck);
        exp_t e;
        logic [31:0] a, b, imm, res, alu;
        logic [4:0] rs1, rs2, rd;
        rs1 = instr[19:15]; rs2 = instr[24:20]; rd = instr[11:7];
        a = mRegs[rs1];
        imm = immOf(instr, inmSrc);
        b = aluSrc ? imm : mRegs[rs2];
        alu = aluOf(a, b, aluControl);
        e.aluRes = alu;
        e.zero = (alu == 32'd0);
        e.writeData = mRegs[rs2];
        e.pc = mPc;
        e.op = instr[6:0];
        e.f3 = instr[14:12];
        e.f7 = instr[30];
        case (resultSrc)
            2'd0: res = alu;
            2'd1: res = readData;
            2'd2: res = 32'(mPc) + 32'd4 & 32'h0000_FFFF;
            default: res = imm;
        endcase
        if (doCheck) expQ.push_back(e);
        @(posedge clk);
        if (rst) begin
            mPc = 16'd0;
            for (int i = 1; i < 32; i++) mRegs[i] = ResetVal;
        end else begin
            if (jump || (branch && e.zero)) mPc = mPc + imm[15:0];
            else mPc = mPc + 16'd4;
            if (regWrite && rd != 5'd0) mRegs[rd] = res;
        end
        #1;
    endtask

    function automatic logic [31:0] rType(input logic [4:0] rs1, input logic [4:0] rs2,
                                          input logic [4:0] rd);
        return {7'd0, rs2, rs1, 3'd0, rd, 7'b0110011};
    endfunction

    function automatic logic [31:0] iType(input logic [11:0] imm, input logic [4:0] rs1,
                                          input logic [4:0] rd);
        return {imm, rs1, 3'd0, rd, 7'b0010011};
    endfunction

    function automatic logic [31:0] bType(input logic [12:0] imm, input logic [4:0] rs1,
                                          input logic [4:0] rs2);
        return {imm[12], imm[10:5], rs2, rs1, 3'd0, imm[4:1], imm[11], 7'b1100011};
    endfunction

    function automatic logic [31:0] jType(input logic [20:0] imm, input logic [4:0] rd);
        return {imm[20], imm[10:1], imm[11], imm[19:12], rd, 7'b1101111};
    endfunction

    task automatic resetAndIdle(input int n);
        rst = 1'b1;
        setc(1'b0, 1'b0, 2'd0, 2'd0, 1'b1, 1'b0, 3'd0, rType(5'd1, 5'd2, 5'd3), 32'd0);
        step(1'b1);
        rst = 1'b0;
        for (int i = 0; i < n; i++) begin
            setc(1'b0, 1'b0, 2'd0, 2'd0, 1'b0, 1'b0, 3'd0, 32'd0, 32'd0);
            step(1'b1);
        end
    endtask

    initial begin : stimulus
        mRegs[0] = 32'd0;
        for (int i = 1; i < 32; i++) mRegs[i] = 32'hx;
        mPc = 16'hx;
        #1;
        rst = 1'b1;
        setc(1'b0, 1'b0, 2'd0, 2'd0, 1'b0, 1'b0, 3'd0, 32'd0, 32'd0);
        step(1'b0);
        rst = 1'b0;

        // PC sequencing and mid-run reset.
        for (int i = 0; i < 4; i++) begin
            setc(1'b0, 1'b0, 2'd0, 2'd0, 1'b0, 1'b0, 3'd0, 32'd0, 32'd0);
            step(1'b1);
        end
        resetAndIdle(1);

        // R-format sequence.
        setc(1'b0, 1'b0, 2'd0, 2'd0, 1'b1, 1'b0, 3'd0, rType(5'd21, 5'd21, 5'd22), 32'd0);
        step(1'b1);
        setc(1'b0, 1'b0, 2'd0, 2'd0, 1'b1, 1'b0, 3'd1, rType(5'd21, 5'd22, 5'd23), 32'd0);
        step(1'b1);
        setc(1'b0, 1'b0, 2'd0, 2'd0, 1'b1, 1'b0, 3'd2, rType(5'd21, 5'd22, 5'd24), 32'd0);
        step(1'b1);
        setc(1'b0, 1'b0, 2'd0, 2'd0, 1'b1, 1'b0, 3'd3, rType(5'd21, 5'd22, 5'd25), 32'd0);
        step(1'b1);
        setc(1'b0, 1'b0, 2'd0, 2'd0, 1'b1, 1'b0, 3'd5, rType(5'd21, 5'd21, 5'd26), 32'd0);
        step(1'b1);
        for (int r = 22; r <= 26; r++) begin
            setc(1'b0, 1'b0, 2'd0, 2'd0, 1'b0, 1'b0, 3'd0, rType(5'(r), 5'(r), 5'd0), 32'd0);
            step(1'b1);
        end

        // Write to x0 is dropped; rs2=x0 gives writeData 0.
        setc(1'b0, 1'b0, 2'd3, 2'd0, 1'b1, 1'b1, 3'd0, iType(12'h7AB, 5'd1, 5'd0), 32'd0);
        step(1'b1);
        setc(1'b0, 1'b0, 2'd0, 2'd0, 1'b0, 1'b0, 3'd0, rType(5'd0, 5'd0, 5'd0), 32'd0);
        step(1'b1);

        // I-imm 0xFFF, add to x1, write back the immediate into x7.
        setc(1'b0, 1'b0, 2'd3, 2'd0, 1'b1, 1'b1, 3'd0, iType(12'hFFF, 5'd1, 5'd7), 32'd0);
        step(1'b1);
        setc(1'b0, 1'b0, 2'd0, 2'd0, 1'b0, 1'b0, 3'd0, rType(5'd7, 5'd7, 5'd0), 32'd0);
        step(1'b1);

        // Load write-back, then read it.
        setc(1'b0, 1'b0, 2'd1, 2'd0, 1'b1, 1'b0, 3'd0, rType(5'd0, 5'd0, 5'd5), 32'hDEADBEEF);
        step(1'b1);
        setc(1'b0, 1'b0, 2'd0, 2'd0, 1'b0, 1'b0, 3'd0, rType(5'd5, 5'd0, 5'd0), 32'd0);
        step(1'b1);

        // pc+4 write-back at pc=8.
        resetAndIdle(2);
        setc(1'b0, 1'b0, 2'd2, 2'd0, 1'b1, 1'b0, 3'd0, rType(5'd0, 5'd0, 5'd6), 32'd0);
        step(1'b1);
        setc(1'b0, 1'b0, 2'd0, 2'd0, 1'b0, 1'b0, 3'd0, rType(5'd6, 5'd6, 5'd0), 32'd0);
        step(1'b1);

        // Branch taken (ALU gives 0) at pc=16, B-imm -8.
        resetAndIdle(4);
        setc(1'b1, 1'b0, 2'd0, 2'd2, 1'b0, 1'b0, 3'd6, bType(13'h1FF8, 5'd1, 5'd2), 32'd0);
        step(1'b1);
        // Branch not taken: x1 | imm is nonzero.
        resetAndIdle(4);
        setc(1'b1, 1'b0, 2'd0, 2'd2, 1'b0, 1'b1, 3'd3, bType(13'h1FF8, 5'd1, 5'd2), 32'd0);
        step(1'b1);
        // Jump +12.
        setc(1'b0, 1'b1, 2'd0, 2'd3, 1'b0, 1'b0, 3'd0, jType(21'd12, 5'd0), 32'd0);
        step(1'b1);
        setc(1'b0, 1'b0, 2'd0, 2'd0, 1'b0, 1'b0, 3'd0, 32'd0, 32'd0);
        step(1'b1);

        // Randomized traffic.
        for (int n = 0; n < 400; n++) begin
            rst = ($urandom_range(0, 49) == 0);
            setc(1'($urandom_range(0, 3) == 0), 1'($urandom_range(0, 7) == 0),
                 2'($urandom), 2'($urandom), 1'($urandom), 1'($urandom),
                 3'($urandom), $urandom, $urandom);
            step(1'b1);
        end
        rst = 1'b0;

        repeat (3) @(negedge clk);
        total++;
        if (expQ.size() != 0) begin
            bad++;
            $display("FAIL drain: got %0d pending expected 0", expQ.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
